uart_rx_core: RTL and testbench

UART_RX_CORE -- requirements
Module: uart_rx_core

---
 rtl/uart_rx_core_if.sv | 39 +++
 rtl/uart_rx_core.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_core.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_core_if.sv
// uart_rx_core_if -- consumer-side bundle of the UART receiver.
//
// Signals:
//   data_out      [7:0]  last received byte (core -> consumer)
//   data_ready           a byte is held and unread (core -> consumer)
//   framing_error        one-cycle pulse, stop bit sampled low (core -> consumer)
//   overrun              sticky, a byte landed on an unread byte (core -> consumer)
//   busy_rx              receiver is inside a frame (core -> consumer)
//   data_rd              consumer acknowledge, clears the holding buffer (consumer -> core)
//
// Modports: master = receiver core, slave = consumer.
`timescale 1ns/1ps

interface uart_rx_core_if;
    logic [7:0] data_out;
    logic       data_ready;
    logic       framing_error;
    logic       overrun;
    logic       busy_rx;
    logic       data_rd;

    modport master (
        output data_out,
        output data_ready,
        output framing_error,
        output overrun,
        output busy_rx,
        input  data_rd
    );

    modport slave (
        input  data_out,
        input  data_ready,
        input  framing_error,
        input  overrun,
        input  busy_rx,
        output data_rd
    );
endinterface

// File: rtl/uart_rx_core.sv
// uart_rx_core -- 8N1 UART receiver with a one-byte holding buffer.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous, active-high reset
//   uart_rx  asynchronous serial line, idle high
//   bus      uart_rx_core_if.master: data_out, data_ready, framing_error,
//            overrun, busy_rx out; data_rd in
//
// Parameters:
//   CLK_HZ   input clock frequency in Hz
//   BAUD     serial bit rate
//
// The line is sampled once per bit at the bit centre: the start edge loads a
// half-bit count, every later sample point is one full bit period apart.
`timescale 1ns/1ps

module uart_rx_core #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  uart_rx,
    uart_rx_core_if.master        bus
);

    localparam int COUNT = CLK_HZ / BAUD;
    localparam int HALF  = COUNT / 2;
    localparam int CNT_W = (COUNT > 2) ? $clog2(COUNT) : 1;

    localparam logic [CNT_W-1:0] COUNT_M1 = CNT_W'(COUNT - 1);
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    // Two-flop synchronizer; both stages idle high so reset never looks like
    // a start bit.
    logic [1:0] sync_reg;
    logic       rx_s;

    state_t           state_reg,   state_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic [2:0]       bit_idx_reg, bit_idx_next;
    logic [7:0]       shift_reg,   shift_next;

    // The byte is handed to the holding buffer one cycle after the stop-bit
    // sample, so the commit is carried through a register.
    logic             commit_reg,  commit_next;
    logic             framing_error_reg, framing_error_next;

    logic [7:0]       data_out_reg;
    logic             data_ready_reg;
    logic             overrun_reg;

    logic             cnt_zero;

    assign rx_s     = sync_reg[1];
    assign cnt_zero = (cnt_reg == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_reg <= 2'b11;
        end else begin
            sync_reg <= {sync_reg[0], uart_rx};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            bit_idx_reg       <= 3'd0;
            shift_reg         <= 8'h00;
            commit_reg        <= 1'b0;
            framing_error_reg <= 1'b0;
        end else begin
            state_reg         <= state_next;
            cnt_reg           <= cnt_next;
            bit_idx_reg       <= bit_idx_next;
            shift_reg         <= shift_next;
            commit_reg        <= commit_next;
            framing_error_reg <= framing_error_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        cnt_next           = cnt_reg;
        bit_idx_next       = bit_idx_reg;
        shift_next         = shift_reg;
        commit_next        = 1'b0;
        framing_error_next = 1'b0;

        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    cnt_next   = HALF_M1;
                    state_next = START;
                end
            end

            START: begin
                if (cnt_zero) begin
                    if (!rx_s) begin
                        state_next   = DATA;
                        cnt_next     = COUNT_M1;
                        bit_idx_next = 3'd0;
                    end else begin
                        // Line went back high before mid start bit: a glitch.
                        state_next = IDLE;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_zero) begin
                    shift_next   = {rx_s, shift_reg[7:1]};
                    cnt_next     = COUNT_M1;
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt_zero) begin
                    if (rx_s) begin
                        commit_next = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        framing_error_next = 1'b1;
                        state_next         = WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            WAIT_HIGH: begin
                // Hold off until the line is released so a break is not
                // decoded as a stream of 0x00 bytes.
                if (rx_s) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Holding buffer. A commit always wins the data; overrun is raised only
    // when the previous byte was unread and not being read this same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out_reg   <= 8'h00;
            data_ready_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else if (commit_reg) begin
            data_out_reg   <= shift_reg;
            data_ready_reg <= 1'b1;
            if (data_ready_reg && !bus.data_rd) begin
                overrun_reg <= 1'b1;
            end
        end else if (bus.data_rd && data_ready_reg) begin
            data_ready_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end
    end

    assign bus.data_out      = data_out_reg;
    assign bus.data_ready    = data_ready_reg;
    assign bus.framing_error = framing_error_reg;
    assign bus.overrun       = overrun_reg;
    assign bus.busy_rx       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// tb_uart_rx_core -- directed bench for uart_rx_core at CLK_HZ=160, BAUD=10
// (16 clocks per bit, half bit 8). Inputs change on the falling clock edge,
// outputs are observed on the falling clock edge.
`timescale 1ns/1ps

module tb_uart_rx_core;

    localparam int BIT_CLKS = 16;

    logic clk;
    logic reset;
    logic uart_rx;

    int checks   = 0;
    int failures = 0;
    int fe_count = 0;
    int fe_before;

    logic rdy_early, rdy_late, busy_mid;

    uart_rx_core_if bus();

    uart_rx_core #(
        .CLK_HZ (160),
        .BAUD   (10)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .uart_rx (uart_rx),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each framing_error pulse is one clock wide, so one falling edge sees it.
    always @(negedge clk) begin
        if (bus.framing_error === 1'b1) fe_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Sends one frame starting at a falling edge; returns at the falling edge
    // that ends the stop bit. The start edge is at negedge n0; the stop bit is
    // sampled on rising edge 154 and the byte commits on rising edge 155.
    task automatic send_frame(input logic [7:0] b, input logic stop_val, input logic rd_at_commit,
                              output logic ready_early, output logic ready_late,
                              output logic busy_stop);
        uart_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (BIT_CLKS) @(negedge clk);
        end
        uart_rx     = stop_val;
        ready_early = 1'bx;
        ready_late  = 1'bx;
        busy_stop   = 1'bx;
        for (int j = 0; j < BIT_CLKS; j++) begin
            if (j == 0)  busy_stop   = bus.busy_rx;
            if (j == 10) ready_early = bus.data_ready;
            if (j == 13) ready_late  = bus.data_ready;
            bus.data_rd = rd_at_commit && (j == 11);
            @(negedge clk);
        end
        bus.data_rd = 1'b0;
    endtask

    task automatic pulse_rd();
        bus.data_rd = 1'b1;
        @(negedge clk);
        bus.data_rd = 1'b0;
    endtask

    initial begin
        bus.data_rd = 1'b0;
        uart_rx     = 1'b1;
        reset       = 1'b0;
        #2 reset    = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_data_out",   bus.data_out,      8'h00);
        check("rst_data_ready", bus.data_ready,    1'b0);
        check("rst_ferr",       bus.framing_error, 1'b0);
        check("rst_overrun",    bus.overrun,       1'b0);
        check("rst_busy",       bus.busy_rx,       1'b0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Byte 0xA5, clean stop bit, no read
        fe_before = fe_count;
        send_frame(8'hA5, 1'b1, 1'b0, rdy_early, rdy_late, busy_mid);
        check("a5_busy_in_stop",   busy_mid,       1'b1);
        check("a5_ready_early",    rdy_early,      1'b0);
        check("a5_ready_late",     rdy_late,       1'b1);
        check("a5_data_out",       bus.data_out,   8'hA5);
        check("a5_data_ready",     bus.data_ready, 1'b1);
        check("a5_overrun",        bus.overrun,    1'b0);
        check("a5_no_ferr",        fe_count,       fe_before);
        check("a5_busy_after",     bus.busy_rx,    1'b0);
        pulse_rd();
        check("a5_rd_clears",      bus.data_ready, 1'b0);
        repeat (4) @(negedge clk);

        // 4-clock glitch on an idle line
        fe_before = fe_count;
        uart_rx = 1'b0;
        repeat (4) @(negedge clk);
        uart_rx = 1'b1;
        check("glitch_busy_during", bus.busy_rx,   1'b1);
        repeat (20) @(negedge clk);
        check("glitch_busy_after",  bus.busy_rx,    1'b0);
        check("glitch_ready",       bus.data_ready, 1'b0);
        check("glitch_no_ferr",     fe_count,       fe_before);
        check("glitch_overrun",     bus.overrun,    1'b0);

        // 0x3C with a low stop bit, then a 40-clock break
        fe_before = fe_count;
        send_frame(8'h3C, 1'b0, 1'b0, rdy_early, rdy_late, busy_mid);
        check("ferr_one_pulse",     fe_count,       fe_before + 1);
        check("ferr_ready",         bus.data_ready, 1'b0);
        repeat (40) @(negedge clk);
        check("ferr_wait_high",     bus.busy_rx,    1'b1);
        check("ferr_no_more_pulse", fe_count,       fe_before + 1);
        uart_rx = 1'b1;
        repeat (4) @(negedge clk);
        check("ferr_idle_again",    bus.busy_rx,    1'b0);
        send_frame(8'h11, 1'b1, 1'b0, rdy_early, rdy_late, busy_mid);
        check("post_ferr_data",     bus.data_out,   8'h11);
        check("post_ferr_ready",    bus.data_ready, 1'b1);
        check("post_ferr_no_ferr",  fe_count,       fe_before + 1);
        pulse_rd();
        check("post_ferr_rd",       bus.data_ready, 1'b0);

        // Back-to-back 0x01, 0x02 without reading -> overrun
        send_frame(8'h01, 1'b1, 1'b0, rdy_early, rdy_late, busy_mid);
        check("ovr_first_overrun",  bus.overrun,    1'b0);
        send_frame(8'h02, 1'b1, 1'b0, rdy_early, rdy_late, busy_mid);
        check("ovr_data_out",       bus.data_out,   8'h02);
        check("ovr_data_ready",     bus.data_ready, 1'b1);
        check("ovr_overrun",        bus.overrun,    1'b1);
        pulse_rd();
        check("ovr_rd_ready",       bus.data_ready, 1'b0);
        check("ovr_rd_overrun",     bus.overrun,    1'b0);
        check("ovr_rd_holds_data",  bus.data_out,   8'h02);

        // 0x44 unread, read strobe exactly on the 0x55 commit cycle
        send_frame(8'h44, 1'b1, 1'b0, rdy_early, rdy_late, busy_mid);
        check("same_44_ready",      bus.data_ready, 1'b1);
        send_frame(8'h55, 1'b1, 1'b1, rdy_early, rdy_late, busy_mid);
        check("same_55_data",       bus.data_out,   8'h55);
        check("same_55_ready",      bus.data_ready, 1'b1);
        check("same_55_overrun",    bus.overrun,    1'b0);

        // Reset during bit D3 of 0xFF (0x55 still unread)
        uart_rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        uart_rx = 1'b1;
        repeat (3 * BIT_CLKS + 8) @(negedge clk);
        check("mid_busy_before_rst", bus.busy_rx,   1'b1);
        reset = 1'b1;
        #1;
        check("mid_rst_data_out",   bus.data_out,      8'h00);
        check("mid_rst_ready",      bus.data_ready,    1'b0);
        check("mid_rst_ferr",       bus.framing_error, 1'b0);
        check("mid_rst_overrun",    bus.overrun,       1'b0);
        check("mid_rst_busy",       bus.busy_rx,       1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        fe_before = fe_count;
        repeat (100) @(negedge clk);
        check("mid_no_commit",      bus.data_ready, 1'b0);
        send_frame(8'h81, 1'b1, 1'b0, rdy_early, rdy_late, busy_mid);
        check("mid_81_data",        bus.data_out,   8'h81);
        check("mid_81_ready",       bus.data_ready, 1'b1);
        check("mid_81_overrun",     bus.overrun,    1'b0);
        check("mid_81_no_ferr",     fe_count,       fe_before);
        check("mid_81_busy",        bus.busy_rx,    1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
